demux_1xn_stream: RTL and testbench
===================================

DEMUX_1XN_STREAM -- requirements
Module: demux_1xn_stream

Interface
REQ-001 SHALL have parameter N, default 8: number of output channels, legal range 2..64.
REQ-002 SHALL have parameter W, default 1: data width in bits, legal range 1..64.
REQ-003 SHALL have derived localparam SW = $clog2(N): select width; not overridable.
REQ-004 SHALL have port clk  input  1  clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  the source presents a word.
REQ-007 SHALL have port in_ready  output  1  the block accepts the word this cycle.
REQ-008 SHALL have port in_data  input  W  payload.
REQ-009 SHALL have port in_sel  input  SW  destination channel index.
REQ-010 SHALL have port out_valid  output  N  per-channel word available.
REQ-011 SHALL have port out_ready  input  N  per-channel sink accepts.
REQ-012 SHALL have port out_data  output  N*W  channel k occupies bits [k*W +: W].
REQ-013 SHALL have port drop_cnt  output  8  count of words dropped for an out-of-range select.

Function
REQ-014 SHALL give each channel a one-entry holding register with a full flag; out_valid[k] equals full[k].
REQ-015 SHALL accept a word (the transfer) when in_valid && in_ready are both high at a rising clk edge.
REQ-016 SHALL drive in_ready = !full[in_sel] || out_ready[in_sel] when in_sel < N (pass-through when full and draining).
REQ-017 SHALL drive in_ready = 1 when in_sel >= N; the transfer drops the word and increments drop_cnt, saturating at 255.
REQ-018 SHALL present an accepted word on out_data[in_sel] with out_valid set on the next cycle (latency 1); no combinational path from in_data to out_data.
REQ-019 SHALL clear full[k] when out_valid[k] && out_ready[k], unless channel k is refilled in the same cycle, in which case full[k] stays 1 and new data is loaded.
REQ-020 SHALL hold out_data[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-021 SHALL leave channels other than in_sel unaffected by a transfer; channels drain independently and concurrently.
REQ-022 SHALL make in_ready independent of in_valid; in_ready may depend on in_sel and out_ready.
REQ-023 SHALL leave the out_data value of an empty channel don't-care; the bench checks it only when out_valid is high.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear all full flags, out_valid, out_data and drop_cnt to 0.
REQ-025 SHALL discard words held at reset assertion mid-operation; no transfer occurs in the first edge after release unless in_valid is high.

Configuration
REQ-026 SHALL, when macro DEMUX_BCAST_EN is defined, add input port in_bcast (1 bit); a transfer with in_bcast=1 writes in_data to all N channels.
REQ-027 SHALL, with DEMUX_BCAST_EN defined and in_bcast=1, drive in_ready = AND over k of (!full[k] || out_ready[k]), ignore in_sel, and leave drop_cnt unchanged.
REQ-028 SHALL, without DEMUX_BCAST_EN, omit the in_bcast port entirely and behave as unicast only.

Structure
REQ-029 SHALL place in package demux_pkg: DROP_CNT_W=8, DROP_CNT_MAX=255, and the default values of N and W.
REQ-030 SHALL implement each channel's holding register as sub-module demux_out_slot (W-bit data plus full flag, load and drain inputs), instantiated N times via generate.

Verification
REQ-031 SHALL verify unicast: N=8, W=8, all out_ready=1, send 0x11..0x88 to channels 0..7 in back-to-back cycles -> each channel shows its word exactly one cycle after its transfer, and in_ready stays 1 throughout.
REQ-032 SHALL verify backpressure: out_ready[3]=0, send 0xA5 then 0x5A to channel 3 -> first word accepted, in_ready=0 for the second, out_data[3] holds 0xA5; raise out_ready[3] -> 0x5A is accepted the same cycle and appears next cycle.
REQ-033 SHALL verify out-of-range select: N=6, send in_sel=7 three times -> in_ready=1, no out_valid rises, drop_cnt=3; then 300 drops -> drop_cnt=255.
REQ-034 SHALL verify reset mid-operation: channels 0 and 5 full, assert rst_n low between edges -> out_valid=0 immediately and drop_cnt=0.
REQ-035 SHALL verify broadcast (DEMUX_BCAST_EN defined): out_ready[2]=0 and channel 2 full, in_bcast=1 -> in_ready=0; release out_ready[2] -> all 8 channels show in_data next cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-N stream demultiplexer.
package demux_pkg;

   localparam int DROP_CNT_W   = 8;
   localparam int DROP_CNT_MAX = 255;
   localparam int DEMUX_N_DEF  = 8;
   localparam int DEMUX_W_DEF  = 1;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register: W-bit word plus a full flag.
// A load always wins over a drain, so a slot that is emptied and refilled
// on the same edge stays full and takes the new word.
module demux_out_slot
   import demux_pkg::*;
#(
   parameter int W = DEMUX_W_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         drain_i,
   input  logic [W-1:0] data_i,
   output logic         full_o,
   output logic [W-1:0] data_o
);

   logic         full_q, full_d;
   logic [W-1:0] data_q, data_d;

   // Next-state: load takes priority, otherwise a drained full slot empties.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (load_i) begin
         full_d = 1'b1;
         data_d = data_i;
      end else if (drain_i && full_q) begin
         full_d = 1'b0;
      end
   end

   // Slot state register; reset discards any held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;

endmodule

// File: rtl/demux_1xn_stream.sv
// 1-to-N valid/ready stream demultiplexer with a one-word register per
// output channel and a saturating counter of words dropped because their
// select pointed past the last channel.
// Optional feature: define DEMUX_BCAST_EN to add the in_bcast input, which
// writes one word into every channel at once.
module demux_1xn_stream
   import demux_pkg::*;
#(
   parameter  int N  = DEMUX_N_DEF,
   parameter  int W  = DEMUX_W_DEF,
   localparam int SW = $clog2(N)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [W-1:0]          in_data,
   input  logic [SW-1:0]         in_sel,
`ifdef DEMUX_BCAST_EN
   input  logic                  in_bcast,
`endif
   output logic [N-1:0]          out_valid,
   input  logic [N-1:0]          out_ready,
   output logic [N*W-1:0]        out_data,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   // Select values span a power of two; entries at or above N are out of range.
   localparam int SEL_SPAN = 1 << SW;

   logic [N-1:0]            full;
   logic [N-1:0]            slot_ok;
   logic [N-1:0]            load;
   logic [SEL_SPAN-1:0]     ok_pad;
   logic [SEL_SPAN-1:0]     range_pad;
   logic                    bcast;
   logic                    sel_in_range;
   logic                    xfer;
   logic                    drop;
   logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (v == DROP_CNT_W'(DROP_CNT_MAX)) ? v : v + 1'b1;
   endfunction

`ifdef DEMUX_BCAST_EN
   assign bcast = in_bcast;
`else
   assign bcast = 1'b0;
`endif

   // A channel can take a word if it is empty or is being drained this cycle.
   assign slot_ok = ~full | out_ready;

   // Widen per-channel readiness to the full select span; out-of-range
   // selects are always ready because their words are simply discarded.
   always_comb begin
      ok_pad    = '1;
      range_pad = '0;
      for (int k = 0; k < N; k++) begin
         ok_pad[k]    = slot_ok[k];
         range_pad[k] = 1'b1;
      end
   end

   assign sel_in_range = range_pad[in_sel];
   assign in_ready     = bcast ? &slot_ok : ok_pad[in_sel];
   assign xfer         = in_valid && in_ready;
   assign drop         = xfer && !bcast && !sel_in_range;

   // Steer the accepted word to the selected channel, or to all on broadcast.
   always_comb begin
      load = '0;
      for (int k = 0; k < N; k++) begin
         load[k] = xfer && (bcast || (sel_in_range && (in_sel == SW'(k))));
      end
   end

   // Drop counter next-state, saturating at its maximum.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop) begin
         drop_cnt_d = sat_inc(drop_cnt_q);
      end
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;

   for (genvar k = 0; k < N; k++) begin : g_slot
      demux_out_slot #(
         .W (W)
      ) u_slot (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (load[k]),
         .drain_i (out_ready[k]),
         .data_i  (in_data),
         .full_o  (full[k]),
         .data_o  (out_data[k*W +: W])
      );
   end

   assign out_valid = full;

endmodule

// File: tb/tb_demux_1xn_stream.sv
// Directed bench for demux_1xn_stream: an 8-channel instance for unicast,
// backpressure, reset and broadcast, and a 6-channel instance for
// out-of-range drops. Broadcast scenario is built only with DEMUX_BCAST_EN.
module tb_demux_1xn_stream;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   // 8-channel, 8-bit instance
   logic        v8, rdy8, b8;
   logic [7:0]  d8;
   logic [2:0]  s8;
   logic [7:0]  ov8, or8;
   logic [63:0] od8;
   logic [7:0]  dc8;

   // 6-channel, 8-bit instance
   logic        v6, rdy6, b6;
   logic [7:0]  d6;
   logic [2:0]  s6;
   logic [5:0]  ov6, or6;
   logic [47:0] od6;
   logic [7:0]  dc6;

   int n_checks = 0;
   int n_fail   = 0;

   demux_1xn_stream #(.N(8), .W(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v8),
      .in_ready  (rdy8),
      .in_data   (d8),
      .in_sel    (s8),
`ifdef DEMUX_BCAST_EN
      .in_bcast  (b8),
`endif
      .out_valid (ov8),
      .out_ready (or8),
      .out_data  (od8),
      .drop_cnt  (dc8)
   );

   demux_1xn_stream #(.N(6), .W(8)) u_dut6 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (v6),
      .in_ready  (rdy6),
      .in_data   (d6),
      .in_sel    (s6),
`ifdef DEMUX_BCAST_EN
      .in_bcast  (b6),
`endif
      .out_valid (ov6),
      .out_ready (or6),
      .out_data  (od6),
      .drop_cnt  (dc6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      v8 = 1'b0; b8 = 1'b0; d8 = '0; s8 = '0; or8 = '1;
      v6 = 1'b0; b6 = 1'b0; d6 = '0; s6 = '0; or6 = '1;
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if (ov8 !== 8'h00) begin
         n_fail++; $display("FAIL reset_out_valid8: got %h expected %h", ov8, 8'h00);
      end
      n_checks++;
      if (dc8 !== 8'd0) begin
         n_fail++; $display("FAIL reset_drop_cnt8: got %0d expected %0d", dc8, 0);
      end
      n_checks++;
      if (ov6 !== 6'h00) begin
         n_fail++; $display("FAIL reset_out_valid6: got %h expected %h", ov6, 6'h00);
      end
      n_checks++;
      if (rdy8 !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready8: got %b expected %b", rdy8, 1'b1);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_unicast();
      logic [7:0] exp;
      or8 = '1;
      for (int i = 0; i < 8; i++) begin
         exp = 8'((i + 1) * 17);
         s8 = 3'(i); d8 = exp; v8 = 1'b1;
         #1;
         n_checks++;
         if (rdy8 !== 1'b1) begin
            n_fail++; $display("FAIL unicast_ready ch%0d: got %b expected %b", i, rdy8, 1'b1);
         end
         tick();
         n_checks++;
         if (ov8 !== 8'(1 << i)) begin
            n_fail++; $display("FAIL unicast_valid ch%0d: got %h expected %h", i, ov8, 8'(1 << i));
         end
         n_checks++;
         if (od8[i*8 +: 8] !== exp) begin
            n_fail++; $display("FAIL unicast_data ch%0d: got %h expected %h", i, od8[i*8 +: 8], exp);
         end
      end
      v8 = 1'b0;
      tick();
      n_checks++;
      if (ov8 !== 8'h00) begin
         n_fail++; $display("FAIL unicast_drained: got %h expected %h", ov8, 8'h00);
      end
   endtask

   task automatic test_backpressure();
      or8 = 8'hF7;
      v8 = 1'b1; s8 = 3'd3; d8 = 8'hA5;
      #1;
      n_checks++;
      if (rdy8 !== 1'b1) begin
         n_fail++; $display("FAIL bp_first_ready: got %b expected %b", rdy8, 1'b1);
      end
      tick();
      n_checks++;
      if (ov8 !== 8'h08 || od8[31:24] !== 8'hA5) begin
         n_fail++; $display("FAIL bp_first_word: got valid %h data %h expected valid 08 data a5", ov8, od8[31:24]);
      end
      d8 = 8'h5A;
      #1;
      n_checks++;
      if (rdy8 !== 1'b0) begin
         n_fail++; $display("FAIL bp_stall_ready: got %b expected %b", rdy8, 1'b0);
      end
      tick();
      n_checks++;
      if (ov8 !== 8'h08 || od8[31:24] !== 8'hA5) begin
         n_fail++; $display("FAIL bp_hold: got valid %h data %h expected valid 08 data a5", ov8, od8[31:24]);
      end
      // another channel proceeds while channel 3 is stalled
      s8 = 3'd1; d8 = 8'h77;
      #1;
      n_checks++;
      if (rdy8 !== 1'b1) begin
         n_fail++; $display("FAIL bp_other_ready: got %b expected %b", rdy8, 1'b1);
      end
      tick();
      n_checks++;
      if (ov8 !== 8'h0A || od8[15:8] !== 8'h77 || od8[31:24] !== 8'hA5) begin
         n_fail++; $display("FAIL bp_other_word: got valid %h d1 %h d3 %h expected 0a 77 a5", ov8, od8[15:8], od8[31:24]);
      end
      s8 = 3'd3; d8 = 8'h5A; or8 = 8'hFF;
      #1;
      n_checks++;
      if (rdy8 !== 1'b1) begin
         n_fail++; $display("FAIL bp_release_ready: got %b expected %b", rdy8, 1'b1);
      end
      tick();
      n_checks++;
      if (ov8 !== 8'h08 || od8[31:24] !== 8'h5A) begin
         n_fail++; $display("FAIL bp_pass_through: got valid %h data %h expected valid 08 data 5a", ov8, od8[31:24]);
      end
      v8 = 1'b0;
      tick();
      n_checks++;
      if (ov8 !== 8'h00) begin
         n_fail++; $display("FAIL bp_drained: got %h expected %h", ov8, 8'h00);
      end
   endtask

   task automatic test_drop();
      or6 = '1;
      v6 = 1'b1; s6 = 3'd7; d6 = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++;
         if (rdy6 !== 1'b1) begin
            n_fail++; $display("FAIL drop_ready #%0d: got %b expected %b", i, rdy6, 1'b1);
         end
         tick();
         n_checks++;
         if (ov6 !== 6'h00) begin
            n_fail++; $display("FAIL drop_no_valid #%0d: got %h expected %h", i, ov6, 6'h00);
         end
      end
      n_checks++;
      if (dc6 !== 8'd3) begin
         n_fail++; $display("FAIL drop_cnt_3: got %0d expected %0d", dc6, 3);
      end
      for (int i = 0; i < 300; i++) begin
         s6 = (i % 2 == 0) ? 3'd6 : 3'd7;
         tick();
      end
      n_checks++;
      if (dc6 !== 8'd255) begin
         n_fail++; $display("FAIL drop_cnt_sat: got %0d expected %0d", dc6, 255);
      end
      n_checks++;
      if (ov6 !== 6'h00) begin
         n_fail++; $display("FAIL drop_no_valid_after_sat: got %h expected %h", ov6, 6'h00);
      end
      s6 = 3'd5; d6 = 8'hE1;
      #1;
      n_checks++;
      if (rdy6 !== 1'b1) begin
         n_fail++; $display("FAIL drop_inrange_ready: got %b expected %b", rdy6, 1'b1);
      end
      tick();
      n_checks++;
      if (ov6 !== 6'h20 || od6[47:40] !== 8'hE1 || dc6 !== 8'd255) begin
         n_fail++; $display("FAIL drop_inrange_word: got valid %h data %h cnt %0d expected 20 e1 255", ov6, od6[47:40], dc6);
      end
      v6 = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      or8 = 8'h00;
      v8 = 1'b1; s8 = 3'd0; d8 = 8'h01;
      tick();
      s8 = 3'd5; d8 = 8'h55;
      tick();
      v8 = 1'b0;
      #1;
      n_checks++;
      if (ov8 !== 8'h21) begin
         n_fail++; $display("FAIL rstmid_prefill: got %h expected %h", ov8, 8'h21);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ov8 !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_valid8: got %h expected %h", ov8, 8'h00);
      end
      n_checks++;
      if (dc6 !== 8'd0) begin
         n_fail++; $display("FAIL rstmid_drop_cnt6: got %0d expected %0d", dc6, 0);
      end
      n_checks++;
      if (od8 !== 64'h0) begin
         n_fail++; $display("FAIL rstmid_data8: got %h expected %h", od8, 64'h0);
      end
      #1 rst_n = 1'b1;
      tick();
      n_checks++;
      if (ov8 !== 8'h00 || ov6 !== 6'h00) begin
         n_fail++; $display("FAIL rstmid_after_release: got %h/%h expected 00/00", ov8, ov6);
      end
      or8 = '1;
   endtask

`ifdef DEMUX_BCAST_EN
   task automatic test_bcast();
      or8 = 8'hFB;
      v8 = 1'b1; b8 = 1'b0; s8 = 3'd2; d8 = 8'h22;
      tick();
      b8 = 1'b1; s8 = 3'd0; d8 = 8'hC3;
      #1;
      n_checks++;
      if (rdy8 !== 1'b0) begin
         n_fail++; $display("FAIL bcast_blocked_ready: got %b expected %b", rdy8, 1'b0);
      end
      tick();
      n_checks++;
      if (ov8 !== 8'h04 || od8[23:16] !== 8'h22) begin
         n_fail++; $display("FAIL bcast_blocked_state: got valid %h d2 %h expected 04 22", ov8, od8[23:16]);
      end
      or8 = 8'hFF;
      #1;
      n_checks++;
      if (rdy8 !== 1'b1) begin
         n_fail++; $display("FAIL bcast_release_ready: got %b expected %b", rdy8, 1'b1);
      end
      tick();
      n_checks++;
      if (ov8 !== 8'hFF) begin
         n_fail++; $display("FAIL bcast_valid: got %h expected %h", ov8, 8'hFF);
      end
      for (int k = 0; k < 8; k++) begin
         n_checks++;
         if (od8[k*8 +: 8] !== 8'hC3) begin
            n_fail++; $display("FAIL bcast_data ch%0d: got %h expected %h", k, od8[k*8 +: 8], 8'hC3);
         end
      end
      n_checks++;
      if (dc8 !== 8'd0) begin
         n_fail++; $display("FAIL bcast_drop_cnt: got %0d expected %0d", dc8, 0);
      end
      v8 = 1'b0; b8 = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_unicast();
      test_backpressure();
      test_drop();
      test_reset_mid();
`ifdef DEMUX_BCAST_EN
      test_bcast();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "time limit");
   end

endmodule
